// File: rtl/multicast_issue_buffer_pkg.sv
// Shared types for the multicast issue buffer.
// Tag/packet widths match the downstream multicast controllers.
package multicast_issue_buffer_pkg;

    localparam int MC_ADDRESS_WIDTH = 4;
    localparam int MC_BITWIDTH      = 16;
    localparam int MC_DEPTH         = 4;
    localparam int MC_COUNT_WIDTH   = 16;

    typedef logic [MC_ADDRESS_WIDTH-1:0] tag_t;

    typedef struct packed {
        tag_t                   tag;
        logic [MC_BITWIDTH-1:0] value;
    } packet_t;

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_t;

endpackage

// File: rtl/multicast_issue_buffer_fifo.sv
// Synchronous packet FIFO feeding the bus output stage.
// Power-of-two depth; pointers wrap naturally.
module mc_packet_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Pointer and occupancy next-state
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/multicast_issue_buffer.sv
// Multicast bus issue buffer: FIFO plus a registered output stage
// that holds each packet until every controller accepts it.
module multicast_issue_buffer
    import multicast_issue_buffer_pkg::*;
#(
    parameter int ADDRESS_WIDTH = MC_ADDRESS_WIDTH,
    parameter int BITWIDTH      = MC_BITWIDTH,
    parameter int DEPTH         = MC_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     program_i,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [ADDRESS_WIDTH-1:0] wr_tag,
    input  logic [BITWIDTH-1:0]      wr_value,
    output logic                     controller_enable,
    input  logic                     controller_ready,
    output logic [ADDRESS_WIDTH-1:0] tag,
    output logic [BITWIDTH-1:0]      input_value,
    output logic [15:0]              issued_count,
    output logic                     busy
);

    localparam int PW = ADDRESS_WIDTH + BITWIDTH;
    localparam int CW = $clog2(DEPTH) + 1;

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] out_tag_q, out_tag_d;
    logic [BITWIDTH-1:0]      out_value_q, out_value_d;
    logic [15:0]              issued_q, issued_d;

    logic [PW-1:0]            fifo_rdata;
    logic [CW-1:0]            fifo_count;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     push;
    logic                     pop;
    logic                     xfer;
    logic                     out_valid;

    assign out_valid = (state_q == HOLD);
    assign wr_ready  = ~fifo_full;
    assign push      = wr_valid & wr_ready;

    assign controller_enable = out_valid & ~program_i;
    assign xfer              = controller_enable & controller_ready;

    assign tag          = out_tag_q;
    assign input_value  = out_valid ? out_value_q : '0;
    assign issued_count = issued_q;
    assign busy         = (fifo_count != '0) | out_valid;

    mc_packet_fifo #(
        .WIDTH (PW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i ({wr_tag, wr_value}),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Output stage: load from FIFO when empty or when the held packet leaves
    always_comb begin
        state_d     = state_q;
        out_tag_d   = out_tag_q;
        out_value_d = out_value_q;
        issued_d    = issued_q;
        pop         = 1'b0;
        if (xfer) begin
            issued_d = issued_q + 16'd1;
        end
        unique case (state_q)
            EMPTY: begin
                if (~fifo_empty & ~program_i) begin
                    pop     = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (xfer) begin
                    if (~fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        state_d = EMPTY;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
        if (pop) begin
            out_tag_d   = fifo_rdata[PW-1:BITWIDTH];
            out_value_d = fifo_rdata[BITWIDTH-1:0];
        end
    end

    // Output stage and transfer counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            out_tag_q   <= '0;
            out_value_q <= '0;
            issued_q    <= '0;
        end else begin
            state_q     <= state_d;
            out_tag_q   <= out_tag_d;
            out_value_q <= out_value_d;
            issued_q    <= issued_d;
        end
    end

endmodule
